// File: rtl/fpu_out_pkg.sv
// Shared widths, the packed result entry and a constant log2 helper for the
// FPU result queue.
package fpu_out_pkg;

  localparam int FPU_DATA_W = 32;
  localparam int FPU_FLAG_W = 4;

  // One completed FPU operation: the result word and its exception flags.
  typedef struct packed {
    logic [FPU_DATA_W-1:0] data;
    logic [FPU_FLAG_W-1:0] flags;
  } fpu_result_t;

  // Ceiling log2, usable in constant expressions (clog2(1) == 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_result_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// combinational read port used to present the queue head without latency.
module fpu_result_ram
  import fpu_out_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FPU_DATA_W + FPU_FLAG_W,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fpu_result_queue.sv
// FPU result queue: buffers up to DEPTH results with their exception flags
// between the FPU doorbell and the host, with occupancy status, sticky flag
// accumulation, overflow capture and a threshold level interrupt.
module fpu_result_queue
  import fpu_out_pkg::*;
#(
  parameter int DATA_W     = FPU_DATA_W,
  parameter int FLAG_W     = FPU_FLAG_W,
  parameter int DEPTH      = 4,
  parameter int IRQ_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_W-1:0]          result,
  input  logic [FLAG_W-1:0]          flags,
  input  logic                       fpu_doorbell_r_i,
  input  logic                       host_pop_i,
  input  logic                       sticky_clr_i,
  input  logic                       fpu_int_en,
  output logic                       fpu_ready,
  output logic [DATA_W-1:0]          fpu_output,
  output logic [FLAG_W-1:0]          fpu_output_flags,
  output logic [clog2(DEPTH+1)-1:0]  fpu_count,
  output logic                       fpu_full,
  output logic [FLAG_W-1:0]          fpu_sticky_flags,
  output logic                       fpu_overflow,
  output logic                       fpu_irq
);

  localparam int PTR_W   = clog2(DEPTH);
  localparam int CNT_W   = clog2(DEPTH + 1);
  localparam int ENTRY_W = DATA_W + FLAG_W;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [FLAG_W-1:0]  sticky_reg, sticky_next;
  logic               overflow_reg, overflow_next;
  logic               irq_reg, irq_next;

  logic               empty;
  logic               full;
  logic               pop_ok;
  logic               push_ok;
  logic               drop;
  logic [ENTRY_W-1:0] head_word;

  // Next-state for pointers, occupancy, sticky status and interrupt level.
  always_comb begin
    empty   = (count_reg == '0);
    full    = (count_reg == DEPTH_C);
    pop_ok  = host_pop_i & ~empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    push_ok = fpu_doorbell_r_i & (~full | pop_ok);
    drop    = fpu_doorbell_r_i & ~push_ok;

    wr_ptr_next = push_ok ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop_ok  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CNT_W'(1);
    end

    // Flags of dropped pushes are kept too so no exception goes unseen.
    sticky_next   = (sticky_clr_i ? '0 : sticky_reg)
                  | (fpu_doorbell_r_i ? flags : '0);
    overflow_next = (~sticky_clr_i & overflow_reg) | drop;

    irq_next = fpu_int_en & ((count_next >= THRESH_C) | overflow_next);
  end

  // Queue control state; reset discards all pending results at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      sticky_reg   <= '0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      sticky_reg   <= sticky_next;
      overflow_reg <= overflow_next;
      irq_reg      <= irq_next;
    end
  end

  fpu_result_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (ENTRY_W),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .write_en (push_ok),
    .wr_addr  (wr_ptr_reg),
    .wr_data  ({result, flags}),
    .rd_addr  (rd_ptr_reg),
    .rd_data  (head_word)
  );

  // Head is masked while empty so stale storage never reaches the host.
  assign fpu_ready        = ~empty;
  assign fpu_full         = full;
  assign fpu_count        = count_reg;
  assign fpu_output       = empty ? '0 : head_word[ENTRY_W-1:FLAG_W];
  assign fpu_output_flags = empty ? '0 : head_word[FLAG_W-1:0];
  assign fpu_sticky_flags = sticky_reg;
  assign fpu_overflow     = overflow_reg;
  assign fpu_irq          = irq_reg;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Bench for fpu_result_queue: two instances (IRQ thresholds 1 and 3) share
// stimulus; a queue-based reference model predicts every output.
module tb_fpu_result_queue;
  import fpu_out_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        fpu_doorbell_r_i;
  logic        host_pop_i;
  logic        sticky_clr_i;
  logic        fpu_int_en;

  logic        d1_ready, d1_full, d1_overflow, d1_irq;
  logic [31:0] d1_output;
  logic [3:0]  d1_oflags, d1_sticky;
  logic [2:0]  d1_count;
  logic        d3_ready, d3_full, d3_overflow, d3_irq;
  logic [31:0] d3_output;
  logic [3:0]  d3_oflags, d3_sticky;
  logic [2:0]  d3_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference model state
  fpu_result_t mq[$];
  logic [3:0]  m_sticky;
  bit          m_ovf;
  bit          m_irq1;
  bit          m_irq3;

  fpu_result_queue #(.DATA_W(32), .FLAG_W(4), .DEPTH(DEPTH), .IRQ_THRESH(1)) dut (
    .clk(clk), .reset_n(reset_n), .result(result), .flags(flags),
    .fpu_doorbell_r_i(fpu_doorbell_r_i), .host_pop_i(host_pop_i),
    .sticky_clr_i(sticky_clr_i), .fpu_int_en(fpu_int_en),
    .fpu_ready(d1_ready), .fpu_output(d1_output), .fpu_output_flags(d1_oflags),
    .fpu_count(d1_count), .fpu_full(d1_full), .fpu_sticky_flags(d1_sticky),
    .fpu_overflow(d1_overflow), .fpu_irq(d1_irq)
  );

  fpu_result_queue #(.DATA_W(32), .FLAG_W(4), .DEPTH(DEPTH), .IRQ_THRESH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .result(result), .flags(flags),
    .fpu_doorbell_r_i(fpu_doorbell_r_i), .host_pop_i(host_pop_i),
    .sticky_clr_i(sticky_clr_i), .fpu_int_en(fpu_int_en),
    .fpu_ready(d3_ready), .fpu_output(d3_output), .fpu_output_flags(d3_oflags),
    .fpu_count(d3_count), .fpu_full(d3_full), .fpu_sticky_flags(d3_sticky),
    .fpu_overflow(d3_overflow), .fpu_irq(d3_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sticky = '0;
    m_ovf    = 1'b0;
    m_irq1   = 1'b0;
    m_irq3   = 1'b0;
  endtask

  // Apply the queue rules to the inputs present at a rising edge.
  task automatic model_edge();
    bit is_empty;
    bit is_full;
    bit do_pop;
    bit do_drop;
    fpu_result_t e;
    is_empty = (mq.size() == 0);
    is_full  = (mq.size() == DEPTH);
    do_pop   = host_pop_i && !is_empty;
    do_drop  = fpu_doorbell_r_i && is_full && !host_pop_i;
    if (do_pop) void'(mq.pop_front());
    if (fpu_doorbell_r_i && !do_drop) begin
      e.data  = result;
      e.flags = flags;
      mq.push_back(e);
    end
    if (sticky_clr_i) begin
      m_sticky = '0;
      m_ovf    = 1'b0;
    end
    if (fpu_doorbell_r_i) m_sticky = m_sticky | flags;
    if (do_drop) m_ovf = 1'b1;
    m_irq1 = fpu_int_en && ((mq.size() >= 1) || m_ovf);
    m_irq3 = fpu_int_en && ((mq.size() >= 3) || m_ovf);
  endtask

  task automatic compare_all();
    fpu_result_t h;
    bit ne;
    ne = (mq.size() != 0);
    h  = ne ? mq[0] : '0;
    check("ready",       64'(d1_ready),    64'(ne));
    check("output",      64'(d1_output),   64'(h.data));
    check("out_flags",   64'(d1_oflags),   64'(h.flags));
    check("count",       64'(d1_count),    64'(mq.size()));
    check("full",        64'(d1_full),     64'(mq.size() == DEPTH));
    check("sticky",      64'(d1_sticky),   64'(m_sticky));
    check("overflow",    64'(d1_overflow), 64'(m_ovf));
    check("irq_t1",      64'(d1_irq),      64'(m_irq1));
    check("irq_t3",      64'(d3_irq),      64'(m_irq3));
    check("t3_count",    64'(d3_count),    64'(mq.size()));
    check("t3_output",   64'(d3_output),   64'(h.data));
    check("t3_overflow", 64'(d3_overflow), 64'(m_ovf));
  endtask

  // One clocked transaction: drive, advance the model at the edge, compare.
  task automatic step(input bit push, input logic [31:0] d, input logic [3:0] f,
                      input bit pop, input bit clr, input bit en);
    fpu_doorbell_r_i = push;
    result           = d;
    flags            = f;
    host_pop_i       = pop;
    sticky_clr_i     = clr;
    fpu_int_en       = en;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    n_txn++;
    $display("txn %0d: push=%0b data=%h flags=%h pop=%0b clr=%0b en=%0b -> count=%0d head=%h sticky=%h ovf=%0b irq=%0b/%0b",
             n_txn, push, d, f, pop, clr, en, d1_count, d1_output, d1_sticky,
             d1_overflow, d1_irq, d3_irq);
  endtask

  initial begin
    logic [31:0] vals [5];
    vals[0] = 32'h4000_0000;
    vals[1] = 32'h4040_0000;
    vals[2] = 32'h4080_0000;
    vals[3] = 32'h40A0_0000;
    vals[4] = 32'h40C0_0000;

    reset_n = 1'b0;
    fpu_doorbell_r_i = 1'b0; host_pop_i = 1'b0; sticky_clr_i = 1'b0;
    fpu_int_en = 1'b0; result = '0; flags = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    #5 reset_n = 1'b1;

    // First push into empty queue is visible one cycle later.
    step(1, 32'h3F80_0000, 4'h1, 0, 0, 1);
    check("first_out",   64'(d1_output), 64'h3F80_0000);
    check("first_irq",   64'(d1_irq),    64'h1);
    check("first_count", 64'(d1_count),  64'h1);
    step(0, 0, 0, 1, 0, 1);
    check("drain_ready", 64'(d1_ready), 64'h0);

    // Fill A..D, then a dropped push while full.
    for (int i = 0; i < 4; i++) step(1, vals[i], 4'(i), 0, 0, 1);
    check("fill_full", 64'(d1_full), 64'h1);
    step(1, vals[4], 4'h0, 0, 0, 1);
    check("ovf_set",   64'(d1_overflow), 64'h1);
    check("ovf_count", 64'(d1_count),    64'h4);
    check("ovf_head",  64'(d1_output),   64'(vals[0]));
    step(0, 0, 0, 0, 1, 1);
    check("ovf_clear", 64'(d1_overflow), 64'h0);

    // Push E with a pop while full: accepted, no overflow, drains B,C,D,E.
    step(1, vals[4], 4'h5, 1, 0, 1);
    check("pp_count", 64'(d1_count),    64'h4);
    check("pp_ovf",   64'(d1_overflow), 64'h0);
    for (int i = 1; i < 5; i++) begin
      check("order", 64'(d1_output), 64'(vals[i]));
      step(0, 0, 0, 1, 0, 1);
    end
    check("empty_out", 64'(d1_output), 64'h0);
    check("empty_irq", 64'(d1_irq),    64'h0);

    // Sticky accumulation, then clear together with a push.
    step(0, 0, 0, 0, 1, 1);
    step(1, 32'h1, 4'h1, 0, 0, 1);
    step(1, 32'h2, 4'h4, 0, 0, 1);
    step(1, 32'h3, 4'h8, 0, 0, 1);
    check("sticky_or", 64'(d1_sticky), 64'hD);
    step(1, 32'h4, 4'h2, 0, 1, 1);
    check("sticky_clr_push", 64'(d1_sticky), 64'h2);
    repeat (4) step(0, 0, 0, 1, 0, 1);

    // Threshold-3 instance in polling mode, then enabled.
    for (int i = 0; i < 3; i++) step(1, vals[i], 4'h0, 0, 0, 0);
    check("t3_poll", 64'(d3_irq), 64'h0);
    step(0, 0, 0, 0, 0, 1);
    check("t3_en", 64'(d3_irq), 64'h1);
    step(0, 0, 0, 1, 0, 1);
    check("t3_below", 64'(d3_irq), 64'h0);

    // Asynchronous reset in the middle of a cycle.
    step(1, vals[3], 4'h3, 0, 0, 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_ready", 64'(d1_ready),  64'h0);
    check("rst_out",   64'(d1_output), 64'h0);
    #3 reset_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 60, $urandom, 4'($urandom),
           $urandom_range(99) < 45, $urandom_range(99) < 8,
           $urandom_range(99) < 85);
    end

    fpu_doorbell_r_i = 1'b0; host_pop_i = 1'b0; sticky_clr_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_result_queue.md
Name: fpu_result_queue

Overview:
- Parametrised successor to the FPU single-entry output register.
- Buffers up to DEPTH completed FPU results with their exception flags, so the host can drain them at its own pace.
- Adds queue status, sticky flag accumulation, overflow detection and a threshold-based level interrupt.
- Sits between the FPU datapath (push on doorbell) and the host register interface (pop on read).

Parameters:
- DATA_W, 32: result width in bits.
- FLAG_W, 4: exception flag width (per result).
- DEPTH, 4: queue entries. Power of two, DEPTH >= 2.
- IRQ_THRESH, 1: occupancy at which the interrupt fires. Range 1..DEPTH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- result  in  DATA_W  FPU result, valid while fpu_doorbell_r_i is high.
- flags  in  FLAG_W  FPU exception flags for that result.
- fpu_doorbell_r_i  in  1  push strobe, one cycle per result.
- host_pop_i  in  1  host consumed the head entry.
- sticky_clr_i  in  1  clears sticky flags and overflow.
- fpu_int_en  in  1  interrupt enable.
- fpu_ready  out  1  queue non-empty.
- fpu_output  out  DATA_W  head result.
- fpu_output_flags  out  FLAG_W  head flags.
- fpu_count  out  $clog2(DEPTH+1)  current occupancy.
- fpu_full  out  1  occupancy == DEPTH.
- fpu_sticky_flags  out  FLAG_W  OR of all flags pushed since last clear.
- fpu_overflow  out  1  sticky; a push was dropped.
- fpu_irq  out  1  level interrupt.

Behaviour:
- Reset and clocking: reset reset_n, asynchronous, active-low; clock clk. All state is updated on the rising edge of clk.
- Reset values: pointers 0, count 0, fpu_ready 0, fpu_full 0, fpu_output 0, fpu_output_flags 0, fpu_sticky_flags 0, fpu_overflow 0, fpu_irq 0. Storage array contents need not be reset.
- Push: fpu_doorbell_r_i=1 and (not full, or pop in the same cycle) writes {result, flags} at wr_ptr. wr_ptr increments and wraps modulo DEPTH.
- Pop: host_pop_i=1 and not empty advances rd_ptr, wrapping modulo DEPTH. Pop while empty is ignored and causes no error.
- Simultaneous push+pop:
  - Non-empty: both occur, count unchanged.
  - Full: pop frees a slot and the push is accepted; no overflow.
  - Empty: pop ignored, push accepted, count becomes 1.
- Overflow: push while full without pop drops the new entry; fpu_overflow is set on the next edge. Queue contents and pointers are unchanged.
- Head outputs: fpu_output/fpu_output_flags show the entry at rd_ptr, combinationally from the storage array. They read 0 when empty.
- Latency: a pushed result is visible at the outputs, and fpu_ready rises, one cycle after the doorbell edge into an empty queue. fpu_ready falls one cycle after the final pop.
- Sticky flags:
  - Each accepted push ORs flags into fpu_sticky_flags. Dropped pushes also OR in, so exceptions are never lost.
  - sticky_clr_i clears fpu_sticky_flags and fpu_overflow.
  - Clear and push in the same cycle: result equals the pushed flags; overflow equals the new overflow condition.
- Interrupt: fpu_irq is registered and equals fpu_int_en & ((next count >= IRQ_THRESH) | next overflow).
  - It rises in the same cycle fpu_count reaches the threshold.
  - It deasserts on the edge after the host drains below the threshold and clears overflow, or after fpu_int_en drops.
- Polling mode (fpu_int_en=0): fpu_irq stays 0; all other behaviour is unchanged.
- Counter width: fpu_count must represent 0..DEPTH, and never exceeds DEPTH or underflows.
- Reset mid-operation: the queue empties immediately and asynchronously; pending results are discarded.

Decomposition:
- Package fpu_out_pkg holds:
  - default widths (FPU_DATA_W=32, FPU_FLAG_W=4);
  - a packed entry typedef fpu_result_t {data, flags};
  - the function clog2 for the pointer and count widths.
- One sub-module, fpu_result_ram: a DEPTH x (DATA_W+FLAG_W) register array with a synchronous write port and an asynchronous read port.
- The pointer, count, sticky and irq logic stays in the top level.

Test Plan:
- Reset, then DEPTH=4: push 0x3F800000/flags 0x1 -> next cycle fpu_ready=1, fpu_output=0x3F800000, fpu_count=1, fpu_irq=1 (int_en=1, THRESH=1).
- Push four results A,B,C,D, then pop four times -> outputs appear in order A,B,C,D. After the last pop, fpu_ready=0, fpu_output=0, fpu_irq=0.
- Full queue, push E without pop -> fpu_overflow=1, fpu_count=4, head still A, fpu_irq=1. Then sticky_clr_i -> fpu_overflow=0.
- Full queue, push E and pop simultaneously -> fpu_count=4, fpu_overflow=0, and E is read last after B,C,D.
- Pushes with flags 0x1, 0x4, 0x8 -> fpu_sticky_flags=0xD. Then sticky_clr_i together with a push of flags 0x2 -> 0x2.
- THRESH=3, int_en=0: push 3 -> fpu_irq=0. Raise int_en -> fpu_irq=1 next cycle. Pop 1 -> fpu_irq=0. Assert reset_n low mid-stream -> all outputs 0 immediately.
